// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline: load-use, jr operand, branch, jump and IRQ entry.
// Optional build macro HAZARD_STATS_EN adds saturating stall_cnt/flush_cnt statistics outputs.
module hazard_ctrl #(
   parameter int LOAD_STALL = 1,
   parameter int IRQ_SYNC   = 2
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_jump,
   input  logic       id_jr,
   input  logic       ex_memread,
   input  logic       ex_regwrite,
   input  logic [4:0] ex_writereg,
   input  logic       mem_memread,
   input  logic [4:0] mem_writereg,
   input  logic       ex_branch_taken,
   input  logic       irq,
   input  logic       irq_mask,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic [1:0] pc_sel,
   output logic       epc_write,
   output logic       irq_ack,
   output logic [1:0] state
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      IRQ_WAIT = 2'd2,
      IRQ_TAKE = 2'd3
   } state_t;

   localparam logic [1:0] SEL_PC4 = 2'd0;
   localparam logic [1:0] SEL_BR  = 2'd1;
   localparam logic [1:0] SEL_JMP = 2'd2;
   localparam logic [1:0] SEL_VEC = 2'd3;

   state_t              cur_state;
   state_t              nxt_state;
   logic [2:0]          stall_ctr;
   logic [2:0]          stall_ctr_nxt;
   logic [IRQ_SYNC-1:0] irq_sync;
   logic                irq_armed;
   logic                lu;
   logic                jrh;
   logic                irq_s;
   logic                irq_req;

   assign lu = ex_memread && (ex_writereg != 5'd0) &&
               ((ex_writereg == id_rs) || (id_uses_rt && (ex_writereg == id_rt)));

   assign jrh = id_jr && (id_rs != 5'd0) &&
                ((ex_regwrite && (ex_writereg == id_rs)) ||
                 (mem_memread && (mem_writereg == id_rs)));

   assign irq_s   = irq_sync[IRQ_SYNC-1] & ~irq_mask;
   assign irq_req = irq_s & irq_armed;
   assign state   = cur_state;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         irq_sync <= '0;
      end else begin
         irq_sync[0] <= irq;
         for (int i = 1; i < IRQ_SYNC; i++) begin
            irq_sync[i] <= irq_sync[i-1];
         end
      end
   end

   // One interrupt per irq_s pulse: disarm on acknowledge, re-arm only once irq_s is seen low.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         irq_armed <= 1'b0;
      end else if (irq_ack) begin
         irq_armed <= 1'b0;
      end else if (!irq_s) begin
         irq_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cur_state <= RUN;
         stall_ctr <= 3'd0;
      end else begin
         cur_state <= nxt_state;
         stall_ctr <= stall_ctr_nxt;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      nxt_state     = cur_state;
      stall_ctr_nxt = stall_ctr;
      if (ex_branch_taken) begin
         // A taken branch always wins; a pending interrupt is deferred so EPC is the target.
         stall_ctr_nxt = 3'd0;
         if ((cur_state == IRQ_TAKE) || (cur_state == IRQ_WAIT) ||
             ((cur_state == RUN) && irq_req)) begin
            nxt_state = IRQ_WAIT;
         end else begin
            nxt_state = RUN;
         end
      end else begin
         case (cur_state)
            RUN: begin
               if (irq_req) begin
                  nxt_state = IRQ_TAKE;
               end else if (!jrh && lu && (LOAD_STALL > 1)) begin
                  nxt_state     = STALL;
                  stall_ctr_nxt = 3'(LOAD_STALL - 1);
               end
            end
            STALL: begin
               stall_ctr_nxt = stall_ctr - 3'd1;
               if (stall_ctr == 3'd1) begin
                  nxt_state = RUN;
               end
            end
            IRQ_WAIT: nxt_state = IRQ_TAKE;
            IRQ_TAKE: nxt_state = RUN;
            default:  nxt_state = RUN;
         endcase
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pc_sel      = SEL_PC4;
      epc_write   = 1'b0;
      irq_ack     = 1'b0;
      if (!reset_b) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (ex_branch_taken) begin
         pc_sel      = SEL_BR;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         case (cur_state)
            RUN: begin
               if (irq_req) begin
                  pc_sel = SEL_PC4;
               end else if (jrh || lu) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end else if (id_jump || id_jr) begin
                  pc_sel      = SEL_JMP;
                  if_id_flush = 1'b1;
               end
            end
            STALL: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
            end
            IRQ_WAIT: pc_sel = SEL_PC4;
            IRQ_TAKE: begin
               epc_write   = 1'b1;
               irq_ack     = 1'b1;
               pc_sel      = SEL_VEC;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end
            default: pc_sel = SEL_PC4;
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         stall_cnt <= 16'd0;
         flush_cnt <= 16'd0;
      end else begin
         if (!pc_write && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (if_id_flush && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LOAD_STALL=1 and 3) share every input.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset_b;
   logic [4:0] id_rs, id_rt, ex_writereg, mem_writereg;
   logic       id_uses_rt, id_jump, id_jr, ex_memread, ex_regwrite, mem_memread;
   logic       ex_branch_taken, irq, irq_mask;

   logic       pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, epc_write1, irq_ack1;
   logic [1:0] pc_sel1, state1;
   logic       pc_write3, if_id_write3, if_id_flush3, id_ex_flush3, epc_write3, irq_ack3;
   logic [1:0] pc_sel3, state3;
`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

   // Control bits: pc_write, if_id_write, if_id_flush, id_ex_flush, pc_sel[1:0], epc_write, irq_ack
   localparam logic [7:0] NORM = 8'b1100_0000;
   localparam logic [7:0] STL  = 8'b0001_0000;
   localparam logic [7:0] BR   = 8'b1111_0100;
   localparam logic [7:0] JMP  = 8'b1110_1000;
   localparam logic [7:0] TAKE = 8'b1111_1111;
   localparam logic [7:0] RST  = 8'b0011_0000;

   logic [19:0] obs, exp;
   int          checks = 0;
   int          failures = 0;

   assign obs = {pc_write1, if_id_write1, if_id_flush1, id_ex_flush1, pc_sel1, epc_write1, irq_ack1, state1,
                 pc_write3, if_id_write3, if_id_flush3, id_ex_flush3, pc_sel3, epc_write3, irq_ack3, state3};

   always #5 clk = ~clk;

   hazard_ctrl #(.LOAD_STALL(1), .IRQ_SYNC(2)) dut1 (
      .clk(clk), .reset_b(reset_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .id_jr(id_jr), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_writereg(ex_writereg), .mem_memread(mem_memread), .mem_writereg(mem_writereg),
      .ex_branch_taken(ex_branch_taken), .irq(irq), .irq_mask(irq_mask),
      .pc_write(pc_write1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
      .id_ex_flush(id_ex_flush1), .pc_sel(pc_sel1), .epc_write(epc_write1), .irq_ack(irq_ack1),
      .state(state1)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
   );

   hazard_ctrl #(.LOAD_STALL(3), .IRQ_SYNC(2)) dut3 (
      .clk(clk), .reset_b(reset_b), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .id_jr(id_jr), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_writereg(ex_writereg), .mem_memread(mem_memread), .mem_writereg(mem_writereg),
      .ex_branch_taken(ex_branch_taken), .irq(irq), .irq_mask(irq_mask),
      .pc_write(pc_write3), .if_id_write(if_id_write3), .if_id_flush(if_id_flush3),
      .id_ex_flush(id_ex_flush3), .pc_sel(pc_sel3), .epc_write(epc_write3), .irq_ack(irq_ack3),
      .state(state3)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
   );

   task automatic clear_in();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0; id_jr = 1'b0;
      ex_memread = 1'b0; ex_regwrite = 1'b0; ex_writereg = 5'd0;
      mem_memread = 1'b0; mem_writereg = 5'd0; ex_branch_taken = 1'b0;
   endtask

   task automatic set_lu5();
      clear_in();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd5; id_rs = 5'd5;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         clear_in();
      end
   endtask

   task automatic test_reset();
      reset_b = 1'b0; irq = 1'b0; irq_mask = 1'b0;
      clear_in();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); ex_branch_taken = 1'b1; id_jump = 1'b1; #1;
         exp = {RST, 2'd0, RST, 2'd0}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL reset_hold[%0d]: got %b need %b", i, obs, exp); end
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if ({stall_cnt1, flush_cnt3} !== 32'd0) begin
         failures++; $display("FAIL stats_reset: got %h need 0", {stall_cnt1, flush_cnt3});
      end
`endif
      @(negedge clk); reset_b = 1'b1; clear_in(); #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL reset_release: got %b need %b", obs, exp); end
      // Reset in the middle of a multi-cycle stall
      @(negedge clk); set_lu5(); #1;
      exp = {STL, 2'd0, STL, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL rst_stall_enter: got %b need %b", obs, exp); end
      @(negedge clk); reset_b = 1'b0; clear_in(); #1;
      exp = {RST, 2'd0, RST, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL rst_mid_stall: got %b need %b", obs, exp); end
      @(negedge clk); reset_b = 1'b1; #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL rst_stall_after: got %b need %b", obs, exp); end
   endtask

   task automatic test_load_use();
      @(negedge clk); set_lu5(); #1;
      exp = {STL, 2'd0, STL, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL lu_c1: got %b need %b", obs, exp); end
      for (int i = 2; i <= 3; i++) begin
         @(negedge clk); clear_in(); id_rs = 5'd5; mem_memread = 1'b1; mem_writereg = 5'd5; #1;
         exp = {NORM, 2'd0, STL, 2'd1}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL lu_c%0d: got %b need %b", i, obs, exp); end
      end
      @(negedge clk); clear_in(); id_rs = 5'd5; #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL lu_c4: got %b need %b", obs, exp); end
   endtask

   task automatic test_no_false_hazard();
      @(negedge clk); clear_in(); ex_memread = 1'b1; ex_regwrite = 1'b1; #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL nf_r0: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); ex_memread = 1'b1; ex_writereg = 5'd7; id_rt = 5'd7; id_rs = 5'd3; #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL nf_rt_unused: got %b need %b", obs, exp); end
      @(negedge clk); id_uses_rt = 1'b1; #1;
      exp = {STL, 2'd0, STL, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL lu_rt_used: got %b need %b", obs, exp); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); clear_in(); #1;
         exp = {NORM, 2'd0, STL, 2'd1}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL lu_rt_tail[%0d]: got %b need %b", i, obs, exp); end
      end
      @(negedge clk); clear_in(); id_jr = 1'b1; ex_regwrite = 1'b1; #1;
      exp = {JMP, 2'd0, JMP, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL nf_jr_r0: got %b need %b", obs, exp); end
   endtask

   task automatic test_jr_hazard();
      @(negedge clk); clear_in(); id_jr = 1'b1; id_rs = 5'd31; ex_regwrite = 1'b1; ex_writereg = 5'd31; #1;
      exp = {STL, 2'd0, STL, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL jrh_ex: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); id_jr = 1'b1; id_rs = 5'd31; #1;
      exp = {JMP, 2'd0, JMP, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL jrh_ex_release: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); id_jr = 1'b1; id_rs = 5'd31; mem_memread = 1'b1; mem_writereg = 5'd31; #1;
      exp = {STL, 2'd0, STL, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL jrh_mem: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); id_jump = 1'b1; #1;
      exp = {JMP, 2'd0, JMP, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL jump: got %b need %b", obs, exp); end
   endtask

   task automatic test_branch_during_stall();
      @(negedge clk); set_lu5(); ex_branch_taken = 1'b1; #1;
      exp = {BR, 2'd0, BR, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_lu_same: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); id_rs = 5'd5; #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_lu_next: got %b need %b", obs, exp); end
      @(negedge clk); set_lu5(); #1;
      exp = {STL, 2'd0, STL, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_in_stall_lu: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); ex_branch_taken = 1'b1; #1;
      exp = {BR, 2'd0, BR, 2'd1}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_in_stall: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL br_in_stall_after: got %b need %b", obs, exp); end
   endtask

   task automatic test_irq();
      @(negedge clk); clear_in(); irq = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL irq_sync_c%0d: got %b need %b", i, obs, exp); end
      end
      @(negedge clk); #1;
      exp = {TAKE, 2'd3, TAKE, 2'd3}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL irq_take: got %b need %b", obs, exp); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL irq_held[%0d]: got %b need %b", i, obs, exp); end
      end
      @(negedge clk); irq = 1'b0;
      idle(3);
      @(negedge clk); irq_mask = 1'b1; irq = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL irq_masked[%0d]: got %b need %b", i, obs, exp); end
      end
      @(negedge clk); irq = 1'b0;
      idle(3);
      irq_mask = 1'b0;
      idle(1);
   endtask

   task automatic test_irq_behind_branch();
      @(negedge clk); clear_in(); irq = 1'b1;
      @(negedge clk);
      @(negedge clk); ex_branch_taken = 1'b1; #1;
      exp = {BR, 2'd0, BR, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL irqbr_branch: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); #1;
      exp = {NORM, 2'd2, NORM, 2'd2}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL irqbr_wait: got %b need %b", obs, exp); end
      @(negedge clk); #1;
      exp = {TAKE, 2'd3, TAKE, 2'd3}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL irqbr_take: got %b need %b", obs, exp); end
      @(negedge clk); #1;
      exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL irqbr_after: got %b need %b", obs, exp); end
      irq = 1'b0;
      idle(4);
      // Branch arriving in the IRQ_TAKE cycle defers the interrupt behind it
      @(negedge clk); irq = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); ex_branch_taken = 1'b1; #1;
      exp = {BR, 2'd3, BR, 2'd3}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL take_br: got %b need %b", obs, exp); end
      @(negedge clk); clear_in(); #1;
      exp = {NORM, 2'd2, NORM, 2'd2}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL take_br_wait: got %b need %b", obs, exp); end
      @(negedge clk); #1;
      exp = {TAKE, 2'd3, TAKE, 2'd3}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL take_br_take: got %b need %b", obs, exp); end
      irq = 1'b0;
      idle(4);
   endtask

   task automatic test_reset_mid_irq();
      @(negedge clk); clear_in(); irq = 1'b1;
      @(negedge clk);
      @(negedge clk); ex_branch_taken = 1'b1;
      @(negedge clk); clear_in(); #1;
      exp = {NORM, 2'd2, NORM, 2'd2}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL rstirq_wait: got %b need %b", obs, exp); end
      @(negedge clk); reset_b = 1'b0; irq = 1'b0; #1;
      exp = {RST, 2'd0, RST, 2'd0}; checks++;
      if (obs !== exp) begin failures++; $display("FAIL rstirq_in_reset: got %b need %b", obs, exp); end
      @(negedge clk); reset_b = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp = {NORM, 2'd0, NORM, 2'd0}; checks++;
         if (obs !== exp) begin failures++; $display("FAIL rstirq_after[%0d]: got %b need %b", i, obs, exp); end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_jr_hazard();
      test_branch_during_stall();
      test_irq();
      test_irq_behind_branch();
      test_reset_mid_irq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
